// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared FSM state type, blanking constants and hex glyph table for the scanner
package seven_seg_pkg;
    typedef enum logic {S_GUARD, S_DRIVE} state_t;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF = 4'hF;
    localparam logic [15:0][6:0] GLYPH = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };
endpackage

// File: rtl/seven_seg_decode.sv
// seven_seg_decode: combinational hex nibble to active-low {g,f,e,d,c,b,a} glyph
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    assign seg = GLYPH[nibble];
endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: 4-digit multiplexed 7-seg driver with guard blanking; SEVEN_SEG_LZ_BLANK_EN adds leading-zero blanking
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int DIV = 100000,
    parameter int GUARD = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [15:0] upd_value,
    input  logic [3:0]  upd_dp,
    input  logic [3:0]  blank_mask,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);
    localparam int CW = $clog2(DIV);
    logic [CW-1:0] cnt;
    logic [1:0] digit;
    state_t state, state_nxt;
    logic [15:0] disp_value, pend_value;
    logic [3:0] disp_dp, pend_dp, an_nxt;
    logic pend_full, pend_full_nxt, slot_end, frame_end, accept, transfer, lz, dark, dp_nxt;
    logic [6:0] glyph, seg_nxt;
    assign slot_end = cnt == CW'(DIV - 1);
    assign frame_end = slot_end && digit == 2'd3;
    assign accept = upd_valid & upd_ready;
    assign transfer = frame_end & pend_full;
    assign pend_full_nxt = accept | (pend_full & ~transfer);
    seven_seg_decode u_decode (.nibble(disp_value[{digit, 2'b00} +: 4]), .seg(glyph));
`ifdef SEVEN_SEG_LZ_BLANK_EN
    assign lz = digit != 2'd0 && (disp_value >> {digit, 2'b00}) == 16'd0;
`else
    assign lz = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            digit <= 2'd0;
            state <= S_GUARD;
        end else begin
            cnt <= slot_end ? '0 : cnt + CW'(1);
            digit <= slot_end ? digit + 2'd1 : digit;
            state <= state_nxt;
        end
    end
    always_comb begin
        state_nxt = slot_end ? S_GUARD : (cnt == CW'(GUARD - 1)) ? S_DRIVE : state;
    end
    always_comb begin
        dark = state == S_GUARD || blank_mask[digit] || lz;
        an_nxt = dark ? AN_OFF : ~(4'd1 << digit);
        seg_nxt = dark ? SEG_BLANK : glyph;
        dp_nxt = dark ? 1'b1 : ~disp_dp[digit];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_value <= '0;
            disp_dp <= '0;
            pend_value <= '0;
            pend_dp <= '0;
            pend_full <= 1'b0;
            upd_ready <= 1'b0;
        end else begin
            pend_full <= pend_full_nxt;
            upd_ready <= ~pend_full_nxt;
            if (accept) begin
                pend_value <= upd_value;
                pend_dp <= upd_dp;
            end
            if (transfer) begin
                disp_value <= pend_value;
                disp_dp <= pend_dp;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an <= AN_OFF;
            seg <= SEG_BLANK;
            dp <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            an <= an_nxt;
            seg <= seg_nxt;
            dp <= dp_nxt;
            frame_done <= frame_end;
        end
    end
endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports clk and rst_n listed first.
REQ-002 The block SHALL have parameter DIV, default 100000, giving clk cycles per digit slot; legal values are 4 and above.
REQ-003 The block SHALL have parameter GUARD, default 16, giving blanking cycles at the start of each slot; legal values are 1 to DIV-2.
REQ-004 The block SHALL have the following ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- upd_valid  in  1  new display word offered.
- upd_ready  out  1  pending buffer empty; the offer is accepted this cycle.
- upd_value  in  16  four hex nibbles; nibble k drives digit k.
- upd_dp  in  4  decimal-point enables, one per digit.
- blank_mask  in  4  forces digit k dark while bit k=1; sampled live.
- an  out  4  digit anodes, active-low.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- frame_done  out  1  one-cycle pulse at the end of each 4-digit frame.

Function
REQ-005 A prescaler SHALL count 0..DIV-1 and then wrap to 0; slot_end is true when the count equals DIV-1.
REQ-006 The digit index SHALL advance 0,1,2,3,0 on each slot_end.
REQ-007 The per-slot FSM SHALL have two states:
- S_GUARD lasts while count < GUARD; an=4'b1111 and seg=7'h7F.
- S_DRIVE lasts from count==GUARD through count==DIV-1.
- slot_end returns the FSM to S_GUARD for the next digit.
REQ-008 In S_DRIVE for digit k: an[k]=0 and all other an bits=1; seg=decode(disp_value nibble k); dp=~disp_dp[k].
REQ-009 All outputs SHALL be registered, so that the outputs reflect the state/count present one cycle earlier.
REQ-010 If blank_mask[k]=1 during digit k's S_DRIVE, then an=4'b1111 and dp=1 for that slot.
REQ-011 Decode SHALL use standard hex glyphs for 0-F, for example 0->7'h40, 4->7'h19, A->7'h08, F->7'h0E.
REQ-012 Handshake: an offer is accepted when upd_valid & upd_ready; the capture goes into the pending register and sets pending_full.
REQ-013 upd_ready SHALL equal ~pending_full, registered.
REQ-014 Pending data SHALL transfer to disp_value/disp_dp on slot_end with digit==3, and pending_full SHALL clear on that transfer; the display never changes mid-frame.
REQ-015 On a simultaneous transfer and upd_valid, the new offer SHALL NOT be accepted that cycle; upd_ready rises the following cycle.
REQ-016 If upd_valid is deasserted with no handshake, nothing SHALL be captured.
REQ-017 frame_done SHALL assert for exactly one cycle on the cycle after slot_end with digit==3.

Reset
REQ-018 While rst_n=0, the block SHALL hold an=4'hF, seg=7'h7F, dp=1, frame_done=0 and upd_ready=0.
REQ-019 While rst_n=0, the internal state SHALL be: prescaler=0, digit=0, state=S_GUARD, disp_value=0, disp_dp=0, pending_full=0.
REQ-020 After reset deassertion, upd_ready SHALL be 1 on the first clk edge.
REQ-021 A reset asserted mid-slot SHALL take effect immediately (asynchronous) and discard any pending word.

Configuration
REQ-022 With SEVEN_SEG_LZ_BLANK_EN defined, any digit k>0 whose nibble and all higher nibbles of disp_value are zero SHALL be blanked as in REQ-010.
REQ-023 Under SEVEN_SEG_LZ_BLANK_EN, digit 0 is never blanked by this rule, so a value of 0 shows "0".
REQ-024 Without SEVEN_SEG_LZ_BLANK_EN, all four digits SHALL display every nibble, and no leading-zero logic SHALL be synthesized.

Structure
REQ-025 Package seven_seg_pkg SHALL hold the FSM state typedef (S_GUARD, S_DRIVE), SEG_BLANK=7'h7F, AN_OFF=4'hF, and the 16-entry glyph constant table.
REQ-026 Sub-module seven_seg_decode SHALL be purely combinational, mapping a 4-bit nibble to seg[6:0]; it is instantiated once and shared by all digits.

Verification (DIV=8, GUARD=2)
REQ-027 Reset test: hold rst_n low for 3 cycles, release, then pulse rst_n low mid-S_DRIVE -> outputs return to an=F, seg=7F at once, with no clock edge required.
REQ-028 Update test: offer 0x1234 -> accepted in 1 cycle; after the next frame boundary, the digit 0 slot shows an=4'b1110 and seg=7'h19 for 6 cycles, preceded by 2 cycles of an=F.
REQ-029 Back-to-back test: hold upd_valid with 0xAAAA, then 0xBBBB -> upd_ready stays 0 until the cycle after the transfer of 0xAAAA, and 0xBBBB appears only one frame later.
REQ-030 Blanking test: blank_mask=4'b0100 with display word 0x5678 -> the digit 2 slot shows an=F for all 8 cycles, while the other digits are unaffected.
REQ-031 Timing test: free-run 5 frames -> frame_done pulses exactly every 32 cycles, and each an bit is low for 6 of every 32 cycles.
REQ-032 Leading-zero test: with SEVEN_SEG_LZ_BLANK_EN defined and display word 0x0042 -> digits 3 and 2 are dark and digits 1 and 0 show 4 and 2; with display word 0x0000, only digit 0 lights and shows 7'h40.
